uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 102 ++++++++++
 tb/tb_uart_tx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path.
//   - tx_state_e : send-sequencer state encoding (IDLE / WAIT_BUSY / WAIT_DONE)
//   - CLK_FREQ, BAUD, BAUD_DIV : default timing constants, shared with the
//     transmitter instance so both sides agree on the bit period.
package uart_pkg;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int BAUD_DIV = CLK_FREQ / BAUD;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with explicit occupancy count.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_en, wr_data   : enqueue strobe and data (ignored while full)
//   rd_en            : dequeue strobe (ignored while empty)
//   rd_data          : head-of-queue data, valid whenever empty=0
//   full, empty      : decoded from count
//   count            : occupancy, 0..2**DEPTH_LOG2
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // full/empty come from the registered count, so a write to a full FIFO
    // is rejected even if a pop happens in the same cycle.
    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_accept) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;   // wraps naturally at DEPTH
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;        // none, or push+pop together
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte buffer and send sequencer in front of a UART transmitter.
// Producers push bytes at full clock rate; the sequencer hands them to the
// UART one at a time and only after the previous byte has been accepted
// (tx_busy rose) and finished (tx_busy fell).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_data, wr_en      : enqueue one byte per cycle while wr_en=1
//   full, empty, count  : FIFO occupancy (full/empty decoded from count)
//   overflow, ovf_clr   : sticky write-while-full flag and its clear
//   tx_data, tx_send    : byte and one-cycle send request to the UART
//   tx_busy             : UART busy, high from the cycle after tx_send to stop bit
//
// UART handshake: tx_send is a single-cycle request qualified with tx_data.
// The UART acknowledges by raising tx_busy the following cycle and signals
// completion by dropping it. A new request is issued only from IDLE, which is
// reached only after tx_busy has been seen high and then low, so tx_send is
// never asserted while tx_busy=1 nor in back-to-back cycles, and tx_data stays
// put from the request until the sequencer leaves WAIT_DONE.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_send,
    input  logic                  tx_busy
);

    import uart_pkg::*;

    tx_state_e         state;
    logic              pop;
    logic [DATA_W-1:0] rd_data;

    // The head byte is taken in the same edge that the sequencer leaves IDLE.
    assign pop = (state == ST_IDLE) && !empty;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Sticky overflow; a new rejected write outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_data <= '0;
            tx_send <= 1'b0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data <= rd_data;
                        tx_send <= 1'b1;
                        state   <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a behavioural UART
// busy model and an expected-byte queue checked on every tx_send.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DATA_W     = 8;
    localparam int BUSY_LEN   = 20;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b0;
    logic [DATA_W-1:0]   wr_data  = '0;
    logic                wr_en    = 1'b0;
    logic                ovf_clr  = 1'b0;
    logic                tx_busy  = 1'b0;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_send;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] exp_q[$];

    // UART model state
    int              busy_cnt   = 0;
    bit              pending    = 1'b0;
    bit              send_prev  = 1'b0;
    bit              force_busy = 1'b0;
    bit              gap_en     = 1'b0;
    bit              fall_valid = 1'b0;
    int              cyc        = 0;
    int              fall_cyc   = 0;
    int              sends      = 0;
    logic [DATA_W-1:0] last_data = '0;

    uart_tx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until the FIFO is drained and the UART model is quiet, then let the
    // sequencer settle back in IDLE.
    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (empty && !tx_busy && !pending && busy_cnt == 0 && !tx_send) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_idle", {31'b0, ok}, 32'd1);
        tick();
        tick();
    endtask

    // ---------------- UART busy model + scoreboard ----------------
    // tx_send seen in cycle n -> tx_busy high from cycle n+1 for BUSY_LEN cycles.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy_cnt   = 0;
            pending    = 1'b0;
            send_prev  = 1'b0;
            fall_valid = 1'b0;
            tx_busy    = force_busy;
        end else begin
            if (tx_send) begin
                sends++;
                check("send_pacing", {31'b0, (tx_busy | pending | send_prev)}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_send: tx_data %0h with no byte expected (t=%0t)", tx_data, $time);
                end else begin
                    check("send_data", tx_data, exp_q.pop_front());
                end
                if (gap_en && fall_valid) begin
                    check("send_gap", cyc - fall_cyc, 32'd2);
                end
                fall_valid = 1'b0;
                last_data  = tx_data;
                pending    = 1'b1;
            end else if (pending) begin
                check("tx_data_hold", tx_data, last_data);
                pending  = 1'b0;
                busy_cnt = BUSY_LEN;
            end else if (busy_cnt > 0) begin
                check("tx_data_hold", tx_data, last_data);
                busy_cnt--;
                if (busy_cnt == 0) begin
                    fall_valid = 1'b1;
                    fall_cyc   = cyc;
                end
            end
            tx_busy   = force_busy || (busy_cnt > 0);
            send_prev = tx_send;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_data;
        int                exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int peak;
        int lat;

        vecs[0] = '{data: 8'hA5, exp_data: 8'hA5, exp_lat: 2};
        vecs[1] = '{data: 8'h00, exp_data: 8'h00, exp_lat: 2};
        vecs[2] = '{data: 8'hFF, exp_data: 8'hFF, exp_lat: 2};
        vecs[3] = '{data: 8'h5A, exp_data: 8'h5A, exp_lat: 2};
        vecs[4] = '{data: 8'h3C, exp_data: 8'h3C, exp_lat: 2};

        // ---- reset ----
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_empty",    {31'b0, empty},    32'd1);
        check("rst_full",     {31'b0, full},     32'd0);
        check("rst_count",    count,             32'd0);
        check("rst_tx_send",  {31'b0, tx_send},  32'd0);
        check("rst_tx_data",  tx_data,           32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);

        // ---- single bytes: latency, data, empty ----
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vecs[v].exp_data);
            wr_en   = 1'b1;
            wr_data = vecs[v].data;
            tick();
            wr_en = 1'b0;
            check("vec_count_after_write", count, 32'd1);
            lat = 1;
            while (!tx_send && lat < 10) begin
                tick();
                lat++;
            end
            check("vec_latency", lat, vecs[v].exp_lat);
            check("vec_tx_data", tx_data, vecs[v].exp_data);
            check("vec_empty",   {31'b0, empty}, 32'd1);
            wait_idle(200);
        end

        // ---- burst 01,02,03 ----
        gap_en     = 1'b1;
        fall_valid = 1'b0;
        peak       = 0;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(8'(k));
            wr_en   = 1'b1;
            wr_data = 8'(k);
            tick();
            if (int'(count) > peak) peak = int'(count);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (int'(count) > peak) peak = int'(count);
        end
        wait_idle(300);
        check("burst_count_peak", peak, 32'd2);
        check("burst_drained", exp_q.size(), 32'd0);
        gap_en = 1'b0;

        // ---- fill and overflow ----
        for (int k = 0; k < 17; k++) exp_q.push_back(8'h40 + 8'(k));
        for (int k = 0; k < 18; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'h40 + 8'(k);
            tick();
            if (k == 2) force_busy = 1'b1;
            if (k == 16) begin
                check("fill_full_at_16",  {31'b0, full},     32'd1);
                check("fill_count_at_16", count,             32'd16);
                check("fill_no_ovf_yet",  {31'b0, overflow}, 32'd0);
            end
        end
        check("ovf_count_held", count,             32'd16);
        check("ovf_full",       {31'b0, full},     32'd1);
        check("ovf_set",        {31'b0, overflow}, 32'd1);
        // clear and set in the same cycle: set wins
        wr_data = 8'hEE;
        ovf_clr = 1'b1;
        tick();
        check("ovf_set_wins", {31'b0, overflow}, 32'd1);
        wr_en = 1'b0;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'b0, overflow}, 32'd0);
        tick();
        check("ovf_stays_clear", {31'b0, overflow}, 32'd0);
        check("ovf_count_unchanged", count, 32'd16);
        force_busy = 1'b0;
        wait_idle(1500);
        check("fill_drained", exp_q.size(), 32'd0);

        // ---- simultaneous push and pop, pointers wrapping ----
        for (int p = 0; p < 10; p++) begin
            exp_q.push_back(8'h80 + 8'(2 * p));
            exp_q.push_back(8'h81 + 8'(2 * p));
            wr_en   = 1'b1;
            wr_data = 8'h80 + 8'(2 * p);
            tick();
            wr_data = 8'h81 + 8'(2 * p);
            tick();
            wr_en = 1'b0;
            check("pushpop_count", count, 32'd1);
            check("pushpop_send",  {31'b0, tx_send}, 32'd1);
            wait_idle(300);
        end
        check("pushpop_drained", exp_q.size(), 32'd0);

        // ---- reset mid-frame ----
        exp_q.push_back(8'hC0);
        for (int k = 0; k < 6; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'hC0 + 8'(k);
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        check("midrst_count_before", count, 32'd5);
        check("midrst_busy_before",  {31'b0, tx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_count",   count,            32'd0);
        check("midrst_empty",   {31'b0, empty},   32'd1);
        check("midrst_tx_send", {31'b0, tx_send}, 32'd0);
        check("midrst_tx_data", tx_data,          32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(8'h3C);
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        check("post_rst_no_send_yet", {31'b0, tx_send}, 32'd0);
        tick();
        check("post_rst_send", {31'b0, tx_send}, 32'd1);
        check("post_rst_data", tx_data,          32'h3C);
        wait_idle(300);

        // ---- final ----
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("total_sends", sends, 32'd47);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
